// File: rtl/br_perf_mon.sv
// br_perf_mon: per-channel branch prediction performance monitor.
// Each channel counts resolved events and mispredictions, with a sticky
// overflow flag. A small RUN/FROZEN/CLEAR FSM gates counting, and readout
// is registered through a channel select.
// Optional build macro BR_PERF_MON_SATURATE_EN: counters hold at their
// maximum value instead of wrapping to zero (the overflow flag sets either way).
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_RUN    | counting events on every channel
// ST_FROZEN | counters and flags hold, incoming events dropped
// ST_CLEAR  | one-cycle state entered with counters zeroed; events dropped
module br_perf_mon #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ev_valid,
  input  logic [NUM_CH-1:0] ev_wrong,
  input  logic              freeze,
  input  logic              unfreeze,
  input  logic              clear,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [CNT_W-1:0]  rd_total,
  output logic [CNT_W-1:0]  rd_wrong,
  output logic              rd_ovf,
  output logic              frozen
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FROZEN = 2'd1,
    ST_CLEAR  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_frozen;
  logic [CNT_W-1:0]   r_total [NUM_CH];
  logic [CNT_W-1:0]   r_wrong [NUM_CH];
  logic [NUM_CH-1:0]  r_ovf;
  logic [SEL_W-1:0]   r_sel;
  logic [CNT_W-1:0]   r_rd_total;
  logic [CNT_W-1:0]   r_rd_wrong;
  logic               r_rd_ovf;
  logic               w_clr;
  logic               w_cnt_en;
  logic [NUM_CH-1:0]  w_tot_inc;
  logic [NUM_CH-1:0]  w_wr_inc;
  logic [CNT_W-1:0]   w_rd_total;
  logic [CNT_W-1:0]   w_rd_wrong;
  logic               w_rd_ovf;

  // Next-state decode; clear beats freeze beats unfreeze.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (clear)       w_state_nxt = ST_CLEAR;
        else if (freeze) w_state_nxt = ST_FROZEN;
      end
      ST_FROZEN: begin
        if (clear)         w_state_nxt = ST_CLEAR;
        else if (unfreeze) w_state_nxt = ST_RUN;
      end
      ST_CLEAR: w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  // Counters are zeroed on the edge entering CLEAR, so a clear request in
  // RUN also drops that cycle's events.
  assign w_clr     = clear && (r_state != ST_CLEAR);
  assign w_cnt_en  = (r_state == ST_RUN) && !clear;
  assign w_tot_inc = ev_valid & {NUM_CH{w_cnt_en}};
  assign w_wr_inc  = w_tot_inc & ev_wrong;

  // State register and registered frozen decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_RUN;
      r_frozen <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_frozen <= (w_state_nxt == ST_FROZEN);
    end
  end

  // Per-channel event/misprediction counters with sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_total[i] <= '0;
        r_wrong[i] <= '0;
      end
      r_ovf <= '0;
    end else if (w_clr) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_total[i] <= '0;
        r_wrong[i] <= '0;
      end
      r_ovf <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_tot_inc[i]) begin
          if (&r_total[i]) begin
            r_ovf[i] <= 1'b1;
`ifdef BR_PERF_MON_SATURATE_EN
            r_total[i] <= r_total[i];
`else
            r_total[i] <= '0;
`endif
          end else begin
            r_total[i] <= r_total[i] + CNT_W'(1);
          end
        end
        if (w_wr_inc[i]) begin
          if (&r_wrong[i]) begin
            r_ovf[i] <= 1'b1;
`ifdef BR_PERF_MON_SATURATE_EN
            r_wrong[i] <= r_wrong[i];
`else
            r_wrong[i] <= '0;
`endif
          end else begin
            r_wrong[i] <= r_wrong[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  // Readout mux; a select with no matching channel reads as zero.
  always_comb begin
    w_rd_total = '0;
    w_rd_wrong = '0;
    w_rd_ovf   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_sel == SEL_W'(i)) begin
        w_rd_total = r_total[i];
        w_rd_wrong = r_wrong[i];
        w_rd_ovf   = r_ovf[i];
      end
    end
  end

  // Select is captured one edge ahead so readout shows post-edge counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel      <= '0;
      r_rd_total <= '0;
      r_rd_wrong <= '0;
      r_rd_ovf   <= 1'b0;
    end else begin
      r_sel      <= rd_sel;
      r_rd_total <= w_rd_total;
      r_rd_wrong <= w_rd_wrong;
      r_rd_ovf   <= w_rd_ovf;
    end
  end

  assign rd_total = r_rd_total;
  assign rd_wrong = r_rd_wrong;
  assign rd_ovf   = r_rd_ovf;
  assign frozen   = r_frozen;

endmodule

// File: tb/tb_br_perf_mon.sv
// Bench for br_perf_mon (NUM_CH=4, CNT_W=4): a behavioural model checked on
// every falling edge, plus hand-computed expectations for directed scenarios.
module tb_br_perf_mon;
  localparam int NCH  = 4;
  localparam int CW   = 4;
  localparam int MAXV = 15;
`ifdef BR_PERF_MON_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] ev_valid, ev_wrong;
  logic           freeze, unfreeze, clear;
  logic [3:0]     rd_sel;
  logic [CW-1:0]  rd_total, rd_wrong;
  logic           rd_ovf, frozen;

  int n_total = 0;
  int n_bad   = 0;

  br_perf_mon #(.NUM_CH(NCH), .CNT_W(CW), .SEL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .ev_valid(ev_valid), .ev_wrong(ev_wrong),
    .freeze(freeze), .unfreeze(unfreeze), .clear(clear), .rd_sel(rd_sel),
    .rd_total(rd_total), .rd_wrong(rd_wrong), .rd_ovf(rd_ovf), .frozen(frozen)
  );

  always #5 clk = ~clk;

  // Model: mode 0=counting, 1=frozen, 2=clearing.
  int m_tot [NCH];
  int m_wr  [NCH];
  bit m_ovf [NCH];
  int m_mode, m_sel, e_tot, e_wr;
  bit e_ovf, e_frz;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin m_tot[i] = 0; m_wr[i] = 0; m_ovf[i] = 0; end
      m_mode = 0; m_sel = 0; e_tot = 0; e_wr = 0; e_ovf = 0; e_frz = 0;
    end else begin
      if (m_sel < NCH) begin
        e_tot = m_tot[m_sel]; e_wr = m_wr[m_sel]; e_ovf = m_ovf[m_sel];
      end else begin
        e_tot = 0; e_wr = 0; e_ovf = 0;
      end
      m_sel = int'(rd_sel);
      if (m_mode == 2) m_mode = 0;
      else if (clear) begin
        for (int i = 0; i < NCH; i++) begin m_tot[i] = 0; m_wr[i] = 0; m_ovf[i] = 0; end
        m_mode = 2;
      end else if (m_mode == 0) begin
        for (int i = 0; i < NCH; i++) begin
          if (ev_valid[i]) begin
            if (m_tot[i] == MAXV) begin m_ovf[i] = 1; m_tot[i] = SAT ? MAXV : 0; end
            else m_tot[i] = m_tot[i] + 1;
            if (ev_wrong[i]) begin
              if (m_wr[i] == MAXV) begin m_ovf[i] = 1; m_wr[i] = SAT ? MAXV : 0; end
              else m_wr[i] = m_wr[i] + 1;
            end
          end
        end
        if (freeze) m_mode = 1;
      end else if (unfreeze) m_mode = 0;
      e_frz = (m_mode == 1);
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    n_total = n_total + 4;
    if (rd_total !== CW'(e_tot)) begin n_bad++; $display("FAIL model_rd_total t=%0t got=%0d exp=%0d", $time, rd_total, e_tot); end
    if (rd_wrong !== CW'(e_wr))  begin n_bad++; $display("FAIL model_rd_wrong t=%0t got=%0d exp=%0d", $time, rd_wrong, e_wr); end
    if (rd_ovf !== e_ovf)        begin n_bad++; $display("FAIL model_rd_ovf t=%0t got=%0b exp=%0b", $time, rd_ovf, e_ovf); end
    if (frozen !== e_frz)        begin n_bad++; $display("FAIL model_frozen t=%0t got=%0b exp=%0b", $time, frozen, e_frz); end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs (driven after a falling edge), return at next falling edge.
  task automatic cyc(input logic [NCH-1:0] v, input logic [NCH-1:0] w,
                     input logic fz, input logic ufz, input logic clr);
    ev_valid = v; ev_wrong = w; freeze = fz; unfreeze = ufz; clear = clr;
    @(negedge clk);
    ev_valid = '0; ev_wrong = '0; freeze = 0; unfreeze = 0; clear = 0;
  endtask

  task automatic read_ch(input int ch, input int et, input int ew, input int eo, input string name);
    rd_sel = 4'(ch);
    cyc('0, '0, 0, 0, 0);
    cyc('0, '0, 0, 0, 0);
    chk({name, "_total"}, int'(rd_total), et);
    chk({name, "_wrong"}, int'(rd_wrong), ew);
    chk({name, "_ovf"},   int'(rd_ovf),   eo);
  endtask

  int frz_cnt;

  initial begin
    rst_n = 0; ev_valid = '0; ev_wrong = '0; freeze = 0; unfreeze = 0; clear = 0; rd_sel = '0;
    repeat (3) @(negedge clk);
    chk("reset_frozen", int'(frozen), 0);
    chk("reset_rd_total", int'(rd_total), 0);
    chk("reset_rd_ovf", int'(rd_ovf), 0);
    rst_n = 1;

    // Two channels active, one mispredicting every time.
    repeat (10) cyc(4'b0011, 4'b0001, 0, 0, 0);
    read_ch(0, 10, 10, 0, "basic_ch0");
    read_ch(1, 10, 0, 0, "basic_ch1");
    read_ch(2, 0, 0, 0, "basic_ch2");
    read_ch(3, 0, 0, 0, "basic_ch3");

    // Wrong flags without valid are ignored.
    cyc('0, '0, 0, 0, 1);
    cyc('0, '0, 0, 0, 0);
    repeat (5) cyc(4'b0000, 4'b1111, 0, 0, 0);
    read_ch(0, 0, 0, 0, "nowrong_ch0");
    read_ch(3, 0, 0, 0, "nowrong_ch3");

    // Freeze window drops events.
    frz_cnt = 0;
    repeat (3) begin cyc(4'b0001, '0, 0, 0, 0); frz_cnt += int'(frozen); end
    cyc('0, '0, 1, 0, 0); frz_cnt += int'(frozen);
    repeat (5) begin cyc(4'b0001, '0, 1, 0, 0); frz_cnt += int'(frozen); end
    cyc('0, '0, 0, 1, 0); frz_cnt += int'(frozen);
    repeat (2) begin cyc(4'b0001, '0, 0, 0, 0); frz_cnt += int'(frozen); end
    chk("freeze_cycles", frz_cnt, 6);
    read_ch(0, 5, 0, 0, "freeze_ch0");

    // Clear wins over a simultaneous freeze.
    cyc('0, '0, 0, 0, 1);
    cyc('0, '0, 0, 0, 0);
    repeat (7) cyc(4'b0001, '0, 0, 0, 0);
    read_ch(0, 7, 0, 0, "preclr_ch0");
    cyc(4'b0001, '0, 1, 0, 1);
    chk("clrfrz_frozen0", int'(frozen), 0);
    cyc(4'b0001, '0, 1, 0, 0);
    chk("clrfrz_frozen1", int'(frozen), 0);
    cyc('0, '0, 0, 0, 0);
    chk("clrfrz_frozen2", int'(frozen), 0);
    read_ch(0, 0, 0, 0, "clrfrz_ch0");

    // Overflow on a 4-bit counter.
    repeat (17) cyc(4'b0100, '0, 0, 0, 0);
    read_ch(2, SAT ? 15 : 1, 0, 1, "ovf_ch2");

    // Readout latency and out-of-range select.
    rd_sel = 4'd2;
    cyc('0, '0, 0, 0, 0);
    rd_sel = 4'd9;
    cyc('0, '0, 0, 0, 0);
    chk("sel2_total", int'(rd_total), SAT ? 15 : 1);
    cyc('0, '0, 0, 0, 0);
    chk("sel9_total", int'(rd_total), 0);
    chk("sel9_ovf", int'(rd_ovf), 0);

    // Reset in the middle of FROZEN.
    rd_sel = 4'd0;
    cyc('0, '0, 1, 0, 0);
    chk("prerst_frozen", int'(frozen), 1);
    #2 rst_n = 0;
    #1 chk("asyncrst_frozen", int'(frozen), 0);
    chk("asyncrst_total", int'(rd_total), 0);
    @(negedge clk);
    rst_n = 1;
    cyc(4'b0001, '0, 0, 0, 0);
    read_ch(0, 1, 0, 0, "rstfrz_ch0");

    // Reset in the middle of CLEAR.
    repeat (3) cyc(4'b0010, 4'b0010, 0, 0, 0);
    cyc('0, '0, 0, 0, 1);
    #2 rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    cyc(4'b0010, 4'b0010, 0, 0, 0);
    read_ch(1, 1, 1, 0, "rstclr_ch1");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/br_perf_mon.md
BR_PERF_MON -- requirements
Module: br_perf_mon

Interface
REQ-001 Parameter NUM_CH, default 4, number of event channels (e.g. 0=cond branch, 1=jal, 2=jalr, 3=return); legal range 1..16.
REQ-002 Parameter CNT_W, default 32, width of every counter; legal range 4..64.
REQ-003 Parameter SEL_W, default 4, width of rd_sel; 2^SEL_W SHALL be at least NUM_CH.
REQ-004 Clock and reset: one clock, clk; reset rst_n, asynchronous, active-low.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 ev_valid  input  NUM_CH  per-channel EX feedback valid; one resolved event per channel per cycle.
REQ-008 ev_wrong  input  NUM_CH  per-channel prediction-incorrect flag; qualified by ev_valid.
REQ-009 freeze  input  1  single-cycle request to stop counting.
REQ-010 unfreeze  input  1  single-cycle request to resume counting.
REQ-011 clear  input  1  single-cycle request to zero all counters and flags.
REQ-012 rd_sel  input  SEL_W  channel index for readout.
REQ-013 rd_total  output  CNT_W  event count of selected channel.
REQ-014 rd_wrong  output  CNT_W  misprediction count of selected channel.
REQ-015 rd_ovf  output  1  sticky overflow flag of selected channel.
REQ-016 frozen  output  1  high while the FSM is in FROZEN.

Function
REQ-017 Per channel i, total[i] SHALL increment by 1 on a cycle with ev_valid[i]=1 and FSM in RUN.
REQ-018 wrong[i] SHALL increment by 1 on a cycle with ev_valid[i]=1, ev_wrong[i]=1 and FSM in RUN; ev_wrong[i] with ev_valid[i]=0 SHALL be ignored.
REQ-019 Channels SHALL count independently; simultaneous events on all channels in one cycle SHALL all be counted.
REQ-020 FSM states: RUN, FROZEN, CLEAR; input priority clear > freeze > unfreeze.
REQ-021 RUN: clear -> CLEAR; freeze -> FROZEN; otherwise stay.
REQ-022 FROZEN: counters and flags hold, events dropped; clear -> CLEAR; unfreeze -> RUN; freeze ignored.
REQ-023 CLEAR: lasts exactly one cycle; all total, wrong and ovf state zeroed at the entry edge; events during CLEAR dropped; next state RUN unconditionally.
REQ-024 unfreeze in RUN and freeze in CLEAR SHALL be ignored.
REQ-025 ovf[i] SHALL set when total[i] or wrong[i] increments from 2^CNT_W-1, and stay set until CLEAR or reset.
REQ-026 Readout SHALL be registered: rd_total/rd_wrong/rd_ovf reflect counter state after edge N for rd_sel sampled at edge N, visible after edge N+1 (one-cycle latency).
REQ-027 rd_sel >= NUM_CH SHALL return rd_total=0, rd_wrong=0, rd_ovf=0.
REQ-028 frozen SHALL be a registered decode of state, 1 only in FROZEN.

Reset
REQ-029 rst_n=0 SHALL asynchronously force state RUN, all counters 0, all ovf 0, rd_total=0, rd_wrong=0, rd_ovf=0, frozen=0.
REQ-030 Reset asserted mid-FROZEN or mid-CLEAR SHALL abort it; first cycle after release SHALL be RUN and count events.

Configuration
REQ-031 Macro BR_PERF_MON_SATURATE_EN: when defined, counters at 2^CNT_W-1 SHALL hold at max on further increments (ovf still sets); when undefined, counters SHALL wrap to 0 (ovf sets).

Verification
REQ-032 Reset release, ev_valid=4'b0011, ev_wrong=4'b0001 for 10 cycles -> ch0 total=10 wrong=10, ch1 total=10 wrong=0, ch2/ch3 0.
REQ-033 ev_wrong=4'b1111 with ev_valid=0 for 5 cycles -> all wrong counters remain 0.
REQ-034 RUN, 3 events ch0, freeze, 5 events, unfreeze, 2 events -> frozen high 6 cycles, ch0 total=5.
REQ-035 freeze and clear same cycle with ch0 total=7 -> CLEAR then RUN, total=0, frozen stays 0.
REQ-036 CNT_W=4, 17 events ch2 -> ovf[2]=1; total=15 with BR_PERF_MON_SATURATE_EN, total=1 without.
REQ-037 rd_sel=2 then rd_sel=9 (NUM_CH=4) -> rd_total shows ch2 one cycle later, then 0.
